multu_hilo: RTL
===============

Name: multu_hilo

Overview:
- Sequential 32-bit unsigned shift-add multiplier with a HI/LO result register pair.
- It is the consuming end of the 6-bit ALU function-code stream that the ALU control unit drives to its multiplier output.
- It decodes MULTU (6'b011001) and runs one iteration per clock while that code is held.
- It writes the 64-bit product into HI/LO only when the controller presents the HiLo-open code 6'b111111 after a completed multiply.
- HI/LO feed the datapath result mux.

Parameters:
WIDTH, 32, operand width; product and HI:LO are 2*WIDTH wide.
MULTU_CODE, 6'b011001, function code that starts and continues a multiply.
HILO_CODE, 6'b111111, function code that commits the product into HI/LO.

Ports:
clk  input  1  system clock; all state changes on posedge.
reset  input  1  asynchronous, active-high; clears all state immediately.
Signal  input  6  function code from ALU control, sampled on posedge clk.
dataA  input  WIDTH  multiplicand; sampled only on the load edge.
dataB  input  WIDTH  multiplier; sampled only on the load edge.
hi  output  WIDTH  HI register, upper half of the committed product.
lo  output  WIDTH  LO register, lower half of the committed product.
busy  output  1  high in RUN.
ready  output  1  high in DONE (product complete, awaiting commit).
abort  output  1  one-cycle pulse when a multiply is abandoned.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; hi=lo=0; product, multiplicand, multiplier, step=0.
  - busy=ready=abort=0.
  - Reset asserted mid-multiply discards the operation; HI/LO are cleared, not preserved.
- Registers:
  - mcand: 2*WIDTH bits, shifted left each step.
  - mplier: WIDTH bits, shifted right each step.
  - prod: 2*WIDTH bits.
  - step: 6 bits, counts 0..32.
- IDLE:
  - On an edge with Signal==MULTU_CODE: load mcand={0,dataA}, mplier=dataB, and perform iteration 1 on that same edge (prod = dataB[0] ? dataA : 0). Then step=1, mcand<<=1, mplier>>=1, go to RUN.
  - Any other code: stay in IDLE; no register changes.
  - HILO_CODE in IDLE is ignored; HI/LO are unchanged.
- RUN, on each edge with Signal==MULTU_CODE:
  - If mplier[0], prod+=mcand (2*WIDTH-bit add, no carry out possible).
  - Then mcand<<=1, mplier>>=1, step+=1.
  - When step becomes 32, go to DONE.
- RUN, on an edge with any other code (including HILO_CODE with step<32):
  - Go to IDLE; abort=1 for one cycle.
  - HI/LO are unchanged; prod is discarded.
- DONE:
  - Signal==HILO_CODE: hi=prod[2W-1:W], lo=prod[W-1:0], go to IDLE.
  - Signal==MULTU_CODE: hold in DONE with prod frozen. This tolerates the controller's extra MULTU cycles.
  - Any other code: stay in DONE, prod frozen. A later HILO_CODE still commits.
  - A new multiply starts only from IDLE. After a commit, a MULTU code still present on the next edge starts a fresh multiply.
- Latency:
  - 32 consecutive MULTU edges (the load edge counts as the first) produce the final product.
  - HI/LO update on the HILO_CODE edge and are visible the following cycle.
  - Minimum load-to-HI/LO: 33 edges.
- Outputs:
  - hi/lo change only on commit or reset.
  - busy = (state==RUN); ready = (state==DONE). Both are decoded combinationally from the registered state.
- Operands: dataA/dataB changes after the load edge have no effect on the operation in flight.
- Edge cases:
  - 0 × anything yields 0.
  - 0xFFFFFFFF × 0xFFFFFFFF yields 0xFFFFFFFE_00000001 with no overflow.
  - Any step value outside 0..32 is unreachable; it forces IDLE on the next edge.

Test Plan:
- Reset mid-RUN (step=10, after hi=0x1234 from a prior commit) -> hi=lo=0, busy=0 immediately, before the next clk edge.
- dataA=6, dataB=7, Signal=MULTU for 32 edges then HILO_CODE -> busy high for 31 cycles, then ready; next cycle hi=0, lo=42, state IDLE.
- dataA=dataB=0xFFFFFFFF, full sequence -> hi=0xFFFFFFFE, lo=0x00000001.
- After hi:lo=0:42, start 5×5 and drive Signal=ADD (6'b100000) at step 12 -> abort pulses 1 cycle, state IDLE, hi:lo stays 0:42; HILO_CODE afterwards leaves it 0:42.
- 3×4 with 35 MULTU edges (3 extra), then 2 AND cycles, then HILO_CODE -> ready holds throughout; lo=12, hi=0.
- dataA changed to 100 on the edge after load for 9×9 -> lo=81; HILO_CODE in IDLE at reset leaves hi=lo=0.

Source files
------------

// File: rtl/multu_hilo.sv
// Sequential unsigned shift-add multiplier driven by the ALU function-code stream.
// The product is committed into the HI/LO pair only on an explicit commit code after completion.
//
// state | meaning
// IDLE  | waiting for MULTU; HI/LO hold the last committed product
// RUN   | one shift-add iteration per MULTU edge; any other code abandons
// DONE  | product complete, waiting for the HiLo-open code to commit
module multu_hilo #(
  parameter int          WIDTH      = 32,
  parameter logic [5:0]  MULTU_CODE = 6'b011001,
  parameter logic [5:0]  HILO_CODE  = 6'b111111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             ready,
  output logic             abort
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'(WIDTH);

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [5:0]         step_q, step_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               abort_q, abort_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      step_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      step_q   <= step_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    step_d   = step_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    abort_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (Signal == MULTU_CODE) begin
          // The load edge also performs the first iteration.
          prod_d   = dataB[0] ? {{WIDTH{1'b0}}, dataA} : '0;
          mcand_d  = {{WIDTH{1'b0}}, dataA} << 1;
          mplier_d = dataB >> 1;
          step_d   = 6'd1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (Signal == MULTU_CODE) begin
          prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          step_d   = step_q + 6'd1;
          if (step_q + 6'd1 == LAST_STEP)
            state_d = DONE;
        end else begin
          state_d = IDLE;
          abort_d = 1'b1;
        end
      end
      DONE: begin
        if (Signal == HILO_CODE) begin
          hi_d    = prod_q[2*WIDTH-1:WIDTH];
          lo_d    = prod_q[WIDTH-1:0];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A corrupted step counter cannot be trusted; recover to IDLE.
    if (step_q > LAST_STEP)
      state_d = IDLE;
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q == RUN);
  assign ready = (state_q == DONE);
  assign abort = abort_q;

endmodule
